// File: rtl/bayer_pkg.sv
// Shared definitions for the Bayer line buffer.
//   BLB_DW          default raw pixel width
//   BLB_IMG_WIDTH   default active pixels per line
//   BLB_IMG_HEIGHT  default active lines per frame
//   blb_state_t     line-buffer FSM states
package bayer_pkg;

  localparam int BLB_DW         = 10;
  localparam int BLB_IMG_WIDTH  = 640;
  localparam int BLB_IMG_HEIGHT = 480;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } blb_state_t;

endpackage

// File: rtl/blb_line_ram.sv
// One-line pixel store, DEPTH x DW, single address.
// A read and a write to the same address happen in one cycle; the read
// returns the previous contents (read-before-write) one cycle later.
// The read register holds its value while i_en is low.
// Ports:
//   CLK      in   clock, rising edge
//   RST      in   synchronous active-high reset (read register only)
//   i_en     in   access strobe (read + write)
//   i_addr   in   column address
//   i_wdata  in   pixel to store
//   o_rdata  out  old contents of i_addr, registered
module blb_line_ram #(
  parameter int DEPTH = 640,
  parameter int DW    = 10,
  parameter int AW    = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (i_en) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST)       o_rdata <= '0;
    else if (i_en) o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/bayer_line_buffer.sv
// Bayer line buffer: stores one sensor line and presents vertically
// aligned pixel pairs for the downstream Bayer-to-RGB stage.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a start-of-frame pixel; other pixels dropped
// FILL   | row 0: pixels only written into the line RAM
// STREAM | rows 1..H-1: each pixel emitted with its upper neighbour
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   PIX_VALID/SOF/DATA raw pixel stream, SOF marks pixel (0,0)
//   DATA_EN           D0/D1/X/Y valid (registered, latency 1)
//   D0 / D1           current-line pixel / same column previous line
//   X / Y             column / row parity of D0
//   FRAME_DONE        pulse with the last DATA_EN of a frame
//   FRAME_ERR         only with BLB_FRAME_CHECK_EN: sticky short/long
//                     frame flag, cleared by RST
module bayer_line_buffer
  import bayer_pkg::*;
#(
  parameter int DW         = BLB_DW,
  parameter int IMG_WIDTH  = BLB_IMG_WIDTH,
  parameter int IMG_HEIGHT = BLB_IMG_HEIGHT
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PIX_VALID,
  input  logic          PIX_SOF,
  input  logic [DW-1:0] PIX_DATA,
  output logic          DATA_EN,
  output logic [DW-1:0] D0,
  output logic [DW-1:0] D1,
  output logic          X,
  output logic          Y,
  output logic          FRAME_DONE
`ifdef BLB_FRAME_CHECK_EN
  ,
  output logic          FRAME_ERR
`endif
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  blb_state_t    r_state, w_state_nxt, w_state_base;
  logic [CW-1:0] r_col, w_col_cur, w_col_nxt;
  logic [RW-1:0] r_row, w_row_cur, w_row_nxt;
  logic          w_restart, w_accept, w_col_last, w_row_last;
  logic          w_stream_pix, w_frame_last;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_restart    = PIX_VALID & PIX_SOF;
    w_accept     = PIX_VALID & (PIX_SOF | (r_state != IDLE));
    // A SOF pixel is always treated as (0,0), whatever the counters hold.
    w_col_cur    = w_restart ? '0 : r_col;
    w_row_cur    = w_restart ? '0 : r_row;
    w_state_base = w_restart ? FILL : r_state;
    w_col_last   = (w_col_cur == CW'(IMG_WIDTH - 1));
    w_row_last   = (w_row_cur == RW'(IMG_HEIGHT - 1));
    w_stream_pix = w_accept & (w_state_base == STREAM);
    w_frame_last = w_stream_pix & w_col_last & w_row_last;

    w_state_nxt  = r_state;
    w_col_nxt    = r_col;
    w_row_nxt    = r_row;
    if (w_accept) begin
      w_state_nxt = w_state_base;
      if (w_state_base == FILL && w_col_last)
        w_state_nxt = STREAM;
      else if (w_frame_last)
        w_state_nxt = IDLE;

      if (w_col_last) begin
        w_col_nxt = '0;
        w_row_nxt = w_row_last ? '0 : w_row_cur + RW'(1);
      end else begin
        w_col_nxt = w_col_cur + CW'(1);
        w_row_nxt = w_row_cur;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_col      <= '0;
      r_row      <= '0;
      DATA_EN    <= 1'b0;
      FRAME_DONE <= 1'b0;
      D0         <= '0;
      X          <= 1'b0;
      Y          <= 1'b0;
    end else begin
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      DATA_EN    <= w_stream_pix;
      FRAME_DONE <= w_frame_last;
      if (w_accept) begin
        D0 <= PIX_DATA;
        X  <= w_col_cur[0];
        Y  <= w_row_cur[0];
      end
    end
  end

  // The RAM read register is D1 itself, so it shares the output latency.
  blb_line_ram #(
    .DEPTH (IMG_WIDTH),
    .DW    (DW),
    .AW    (CW)
  ) u_line_ram (
    .CLK     (CLK),
    .RST     (RST),
    .i_en    (w_accept & ~RST),
    .i_addr  (w_col_cur),
    .i_wdata (PIX_DATA),
    .o_rdata (D1)
  );

`ifdef BLB_FRAME_CHECK_EN
  logic r_done_once;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_done_once <= 1'b0;
      FRAME_ERR   <= 1'b0;
    end else begin
      if (w_frame_last) r_done_once <= 1'b1;
      if ((w_restart && r_state != IDLE) ||
          (PIX_VALID && !PIX_SOF && r_state == IDLE && r_done_once))
        FRAME_ERR <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bayer_line_buffer.sv
module tb_bayer_line_buffer;

  localparam int DW = 10;
  localparam int W  = 4;
  localparam int H  = 3;

  typedef logic [2*DW+4:0] vec_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          PIX_VALID, PIX_SOF;
  logic [DW-1:0] PIX_DATA;
  logic          DATA_EN, X, Y, FRAME_DONE;
  logic [DW-1:0] D0, D1;
  logic          w_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  bayer_line_buffer #(.DW(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PIX_VALID  (PIX_VALID),
    .PIX_SOF    (PIX_SOF),
    .PIX_DATA   (PIX_DATA),
    .DATA_EN    (DATA_EN),
    .D0         (D0),
    .D1         (D1),
    .X          (X),
    .Y          (Y),
    .FRAME_DONE (FRAME_DONE)
`ifdef BLB_FRAME_CHECK_EN
    ,
    .FRAME_ERR  (w_err)
`endif
  );

`ifndef BLB_FRAME_CHECK_EN
  assign w_err = 1'b0;
`endif

  // Reference model: frame position as a linear pixel index, one stored line.
  logic [DW-1:0] m_line [W];
  bit            m_line_k [W];
  int            m_pos;
  bit            m_in_frame, m_done_once, m_err;
  logic          e_en, e_done, e_x, e_y, e_d1k;
  logic [DW-1:0] e_d0, e_d1;

  function automatic vec_t exp_vec();
`ifdef BLB_FRAME_CHECK_EN
    return {e_en, e_done, e_d0, e_d1, e_x, e_y, m_err};
`else
    return {e_en, e_done, e_d0, e_d1, e_x, e_y, 1'b0};
`endif
  endfunction

  // D1 is left out where the model cannot know the RAM (never written).
  function automatic vec_t obs_vec();
    return {DATA_EN, FRAME_DONE, D0, (e_d1k ? D1 : e_d1), X, Y, w_err};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_in_frame = 0; m_done_once = 0; m_err = 0;
    e_en = 0; e_done = 0; e_d0 = '0; e_d1 = '0; e_x = 0; e_y = 0; e_d1k = 1;
  endtask

  task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
    int r, c;
    PIX_VALID = v; PIX_SOF = s; PIX_DATA = d;
    if (v && s) begin
      if (m_in_frame) m_err = 1;
      m_pos = 0; m_in_frame = 1;
    end else if (v && !m_in_frame && m_done_once) begin
      m_err = 1;
    end
    if (v && m_in_frame) begin
      r = m_pos / W; c = m_pos % W;
      e_d0 = d; e_d1 = m_line[c]; e_d1k = m_line_k[c];
      m_line[c] = d; m_line_k[c] = 1;
      e_x = c[0]; e_y = r[0];
      e_en = (r >= 1);
      e_done = (m_pos == W*H-1);
      m_pos++;
      if (m_pos == W*H) begin m_in_frame = 0; m_done_once = 1; end
    end else begin
      e_en = 0; e_done = 0;
    end
    @(posedge CLK); #1;
    PIX_VALID = 0; PIX_SOF = 0;
  endtask

  task automatic do_reset();
    RST = 1; PIX_VALID = 0; PIX_SOF = 0;
    @(posedge CLK); #1;
    RST = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset_state: got %h required %h", obs_vec(), exp_vec());
    end
    n_cmp++;
    if (D1 !== '0) begin
      n_err++; $display("FAIL reset_d1: got %0d required 0", D1);
    end
  endtask

  task automatic test_continuous();
    int beats = 0, dones = 0;
    logic [2*DW+1:0] first_b = '0, last_b = '0;
    for (int i = 0; i < W*H; i++) begin
      step(1, i == 0, DW'(10*(i/W + 1) + i%W));
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL cont_px%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      if (DATA_EN) begin
        beats++;
        if (beats == 1) first_b = {D0, D1, X, Y};
        last_b = {D0, D1, X, Y};
      end
      if (FRAME_DONE) dones++;
    end
    step(0, 0, '0);
    n_cmp++;
    if (beats != 8 || dones != 1) begin
      n_err++; $display("FAIL cont_counts: got beats=%0d dones=%0d required 8/1", beats, dones);
    end
    n_cmp++;
    if (first_b !== {10'd20, 10'd10, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL cont_first: got %h required D0=20 D1=10 X=0 Y=1", first_b);
    end
    n_cmp++;
    if (last_b !== {10'd33, 10'd23, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL cont_last: got %h required D0=33 D1=23 X=1 Y=0", last_b);
    end
  endtask

  task automatic test_gapped();
    int beats = 0;
    for (int i = 0; i < W*H; i++) begin
      step(1, i == 0, DW'(10*(i/W + 1) + i%W));
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL gap_px%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      if (DATA_EN) beats++;
      step(0, $urandom_range(0, 1), DW'($urandom));
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL gap_hold%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (beats != 8) begin
      n_err++; $display("FAIL gap_beats: got %0d required 8", beats);
    end
  endtask

  task automatic test_no_sof();
    logic [DW-1:0] first_d1 = '1;
    int beats = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, DW'($urandom));
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL nosof_px%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < W*H; i++) begin
      step(1, i == 0, DW'(10*(i/W + 1) + i%W));
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL nosof_frame%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      if (DATA_EN) begin beats++; if (beats == 1) first_d1 = D1; end
    end
    n_cmp++;
    if (first_d1 !== 10'd10) begin
      n_err++; $display("FAIL nosof_d1: got %0d required 10", first_d1);
    end
  endtask

  task automatic test_restart();
    int dones = 0, beats = 0;
    logic [2*DW:0] first_b = '0;
    for (int i = 0; i < W + 2; i++) begin
      step(1, i == 0, DW'(70 + i));
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL rst_part%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      if (FRAME_DONE) dones++;
    end
    for (int i = 0; i < W*H; i++) begin
      step(1, i == 0, DW'(10*(i/W + 4) + i%W));
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL restart_px%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      if (DATA_EN) begin beats++; if (beats == 1) first_b = {D0, D1, Y}; end
      if (FRAME_DONE) dones++;
    end
    n_cmp++;
    if (first_b !== {10'd50, 10'd40, 1'b1} || dones != 1) begin
      n_err++; $display("FAIL restart_first: got %h dones=%0d required D0=50 D1=40 Y=1 dones=1", first_b, dones);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2*W + 2; i++) step(1, i == 0, DW'($urandom));
    do_reset();
    n_cmp++;
    if (obs_vec() !== exp_vec() || D1 !== '0) begin
      n_err++; $display("FAIL midrst_zero: got %h d1=%0d required %h d1=0", obs_vec(), D1, exp_vec());
    end
    step(1, 0, DW'($urandom));
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL midrst_nosof: got %h required %h", obs_vec(), exp_vec());
    end
    test_continuous();
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    do_reset();
    for (int i = 0; i < 2*W*H; i++) begin
      step(1, (i % (W*H)) == 0, DW'($urandom));
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL b2b_px%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      if (FRAME_DONE) dones++;
    end
    step(0, 0, '0);
    n_cmp++;
    if (dones != 2 || w_err !== 1'b0) begin
      n_err++; $display("FAIL b2b_done: got dones=%0d err=%b required 2/0", dones, w_err);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < W*H; i++) begin
        while ($urandom_range(0, 3) == 0) begin
          step(0, 0, DW'($urandom));
          n_cmp++;
          if (obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL rnd_gap f%0d p%0d: got %h required %h", f, i, obs_vec(), exp_vec());
          end
        end
        step(1, i == 0 || $urandom_range(0, 39) == 0, DW'($urandom));
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
          n_err++; $display("FAIL rnd_px f%0d p%0d: got %h required %h", f, i, obs_vec(), exp_vec());
        end
      end
      if (f == 2) begin
        step(1, 0, DW'($urandom));
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
          n_err++; $display("FAIL rnd_long f%0d: got %h required %h", f, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    RST = 1; PIX_VALID = 0; PIX_SOF = 0; PIX_DATA = '0;
    for (int i = 0; i < W; i++) m_line_k[i] = 0;
    model_reset();
    test_reset();
    test_continuous();
    test_gapped();
    test_no_sof();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
